// File: rtl/match_scan_pkg.sv
// Shared types and constants for the match_scan_ctrl word-compare sequencer.
package match_scan_pkg;

    typedef enum logic [1:0] {
        LOAD,
        SCAN,
        DONE
    } state_t;

    localparam int DEFAULT_DW = 8;
    localparam int DEFAULT_N  = 8;

    // Width of an index able to address words 0..n-1.
    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/match_word_bank.sv
// N x DW word store: one synchronous write port, key (word 0) and one indexed
// word read combinationally.
module match_word_bank
    import match_scan_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int N  = DEFAULT_N
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [clog2(N)-1:0]    waddr,
    input  logic [DW-1:0]          wdata,
    input  logic [clog2(N)-1:0]    raddr,
    output logic [DW-1:0]          key,
    output logic [DW-1:0]          rdata
);

    logic [DW-1:0] mem [N];

    // NOTE: storage is deliberately not reset; every word is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign key   = mem[0];
    assign rdata = mem[raddr];

endmodule

// File: rtl/match_scan_ctrl.sv
// Loads N words, compares words 1..N-1 against word 0 one per cycle and
// presents the mismatch flags. Optional match counter: MATCH_SCAN_COUNT_EN.
module match_scan_ctrl
    import match_scan_pkg::*;
#(
    parameter int DW = DEFAULT_DW,
    parameter int N  = DEFAULT_N
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DW-1:0]       in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N-1:0]        flag,
    output logic                busy
`ifdef MATCH_SCAN_COUNT_EN
    ,
    output logic [clog2(N)-1:0] match_cnt
`endif
);

    localparam int IW = clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t          state;
    state_t          state_next;
    logic [IW-1:0]   load_idx;
    logic [IW-1:0]   scan_idx;
    logic [N-1:1]    flag_hi;
    logic [DW-1:0]   key;
    logic [DW-1:0]   word;
    logic            sync_clr;
    logic            accept;
    logic            last_load;
    logic            last_scan;
    logic            differ;

    assign sync_clr  = rst || clr;
    assign accept    = in_valid && in_ready;
    assign last_load = (load_idx == LAST_IDX);
    assign last_scan = (scan_idx == LAST_IDX);
    assign differ    = (word != key);

    match_word_bank #(
        .DW (DW),
        .N  (N)
    ) u_bank (
        .clk   (clk),
        .we    (accept && !sync_clr),
        .waddr (load_idx),
        .wdata (in_data),
        .raddr (scan_idx),
        .key   (key),
        .rdata (word)
    );

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (sync_clr) state <= LOAD;
        else          state <= state_next;
    end

    // NOTE: state_next defaults to the current state so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (accept && last_load) state_next = SCAN;
            SCAN:    if (last_scan)           state_next = DONE;
            DONE:    if (out_ready)           state_next = LOAD;
            default:                          state_next = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            LOAD:    in_ready = 1'b1;
            SCAN:    busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    // Indices and flag register; flags are cleared on SCAN entry, not on frame return.
    always_ff @(posedge clk) begin
        if (sync_clr) begin
            load_idx <= '0;
            scan_idx <= IW'(1);
            flag_hi  <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        load_idx <= last_load ? '0 : load_idx + IW'(1);
                        if (last_load) flag_hi <= '0;
                    end
                end
                SCAN: begin
                    flag_hi[scan_idx] <= differ;
                    scan_idx          <= last_scan ? IW'(1) : scan_idx + IW'(1);
                end
                DONE: begin
                    if (out_ready) begin
                        load_idx <= '0;
                        scan_idx <= IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign flag = {flag_hi, 1'b0};

`ifdef MATCH_SCAN_COUNT_EN
    always_ff @(posedge clk) begin
        if (sync_clr)
            match_cnt <= '0;
        else if (state == LOAD && accept && last_load)
            match_cnt <= '0;
        else if (state == SCAN && !differ)
            match_cnt <= match_cnt + IW'(1);
    end
`endif

endmodule

// File: tb/tb_match_scan_ctrl.sv
// Scoreboard bench for match_scan_ctrl (N=8, DW=8); checks match_cnt when
// MATCH_SCAN_COUNT_EN is defined.
module tb_match_scan_ctrl;

    typedef logic [7:0] frame_t [8];
    typedef struct {
        logic [7:0] flag;
        logic [2:0] cnt;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       clr;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] flag;
    logic       busy;
    logic [2:0] match_cnt;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    match_scan_ctrl #(
        .DW (8),
        .N  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .flag      (flag),
        .busy      (busy)
`ifdef MATCH_SCAN_COUNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

`ifndef MATCH_SCAN_COUNT_EN
    assign match_cnt = 3'd0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: a transfer happens at the next edge when valid&&ready and no reset/abort.
    always @(negedge clk) begin
        if (!rst && !clr && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(flag), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("flag", 32'(flag), 32'(e.flag));
`ifdef MATCH_SCAN_COUNT_EN
                check("match_cnt", 32'(match_cnt), 32'(e.cnt));
`endif
            end
        end
    end

    task automatic send_frame(input frame_t w);
        for (int i = 0; i < 8; i++) begin
            int guard;
            guard    = 0;
            in_valid = 1'b1;
            in_data  = w[i];
            while (!in_ready && guard < 40) begin
                tick();
                guard++;
            end
            if (!in_ready) check("in_ready_timeout", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    // Latency counted in edges, the accepting edge being the first.
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        if (!out_valid) check("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    initial begin
        frame_t fa, fb, fc, fd, fe, fr, junk;
        exp_t   e;
        int     lat;
        int     idx;
        int     guard;
        logic   acc;

        fa   = '{8'h5A, 8'h5A, 8'h00, 8'h5A, 8'hFF, 8'h5A, 8'h5A, 8'h12};
        fb   = '{8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33, 8'h33};
        fc   = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h80};
        fd   = '{8'h77, 8'h77, 8'h00, 8'h77, 8'h77, 8'h77, 8'h77, 8'h76};
        fe   = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        fr   = '{8'h11, 8'h22, 8'h11, 8'h33, 8'h11, 8'h44, 8'h11, 8'h55};
        junk = '{8'h99, 8'h98, 8'h97, 8'h96, 8'h95, 8'h94, 8'h93, 8'h92};

        rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_busy",      32'(busy),      32'd0);
        check("reset_flag",      32'(flag),      32'd0);
`ifdef MATCH_SCAN_COUNT_EN
        check("reset_match_cnt", 32'(match_cnt), 32'd0);
`endif

        // Frame A, out_ready high before out_valid.
        out_ready = 1'b1;
        e.flag = 8'h94; e.cnt = 3'd4; sb.push_back(e);
        send_frame(fa);
        check("scan_busy", 32'(busy), 32'd1);
        wait_out(lat);
        check("latency_a", 32'(lat), 32'd8);
        tick();
        check("one_cycle_done", 32'(out_valid), 32'd0);

        e.flag = 8'h00; e.cnt = 3'd7; sb.push_back(e);
        send_frame(fb);
        wait_out(lat);
        tick();

        e.flag = 8'hFE; e.cnt = 3'd0; sb.push_back(e);
        send_frame(fc);
        wait_out(lat);
        tick();

        // Random in_valid during LOAD, held high with junk through SCAN/DONE, back-pressure.
        out_ready = 1'b0;
        e.flag = 8'hAA; e.cnt = 3'd3; sb.push_back(e);
        idx = 0; guard = 0;
        while (idx < 8 && guard < 200) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = fr[idx];
            acc      = in_valid && in_ready;
            tick();
            if (acc) idx++;
            guard++;
        end
        check("random_load_words", 32'(idx), 32'd8);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int i = 0; i < 7; i++) begin
            check("in_ready_scan", 32'(in_ready), 32'd0);
            tick();
        end
        for (int i = 0; i < 20; i++) begin
            check("hold_valid",    32'(out_valid), 32'd1);
            check("hold_flag",     32'(flag),      32'hAA);
            check("in_ready_done", 32'(in_ready),  32'd0);
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;
        check("ready_after_xfer", 32'(in_ready),  32'd1);
        check("valid_after_xfer", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        e.flag = 8'h94; e.cnt = 3'd4; sb.push_back(e);
        send_frame(fa);
        wait_out(lat);
        check("latency_second", 32'(lat), 32'd8);
        tick();

        // clr after four words, then a fresh frame.
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = junk[i];
            tick();
        end
        in_valid = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_load_ready", 32'(in_ready), 32'd1);
        check("clr_load_busy",  32'(busy),     32'd0);
        e.flag = 8'h84; e.cnt = 3'd5; sb.push_back(e);
        send_frame(fd);
        wait_out(lat);
        check("latency_d", 32'(lat), 32'd8);
        tick();

        // clr in SCAN cycle 3.
        send_frame(fe);
        tick();
        tick();
        check("scan3_partial_flag", 32'(flag), 32'h06);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_scan_flag",  32'(flag),      32'd0);
        check("clr_scan_valid", 32'(out_valid), 32'd0);
        check("clr_scan_ready", 32'(in_ready),  32'd1);
        check("clr_scan_busy",  32'(busy),      32'd0);

        // rst in DONE with out_ready high: reset wins, no transfer.
        out_ready = 1'b0;
        send_frame(fe);
        wait_out(lat);
        check("done_flag_fe", 32'(flag), 32'hFE);
        out_ready = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b0;
        check("rst_done_valid", 32'(out_valid), 32'd0);
        check("rst_done_flag",  32'(flag),      32'd0);
        check("rst_done_ready", 32'(in_ready),  32'd1);

        out_ready = 1'b1;
        e.flag = 8'h00; e.cnt = 3'd7; sb.push_back(e);
        send_frame(fb);
        wait_out(lat);
        tick();
        tick();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/match_scan_ctrl.md
Name: match_scan_ctrl

Overview:
- Sequencer for the 8-word "compare against word 0" flag datapath.
- Accepts N words serially over a valid/ready input; word 0 is the key.
- Time-shares one DW-bit equality comparator across words 1..N-1, one word per cycle.
- Presents the N-bit mismatch flag vector over a valid/ready output; sits between the input entry logic and the result display/decoder.

Parameters:
- DW, 8, data word width in bits.
- N, 8, words per frame including the key word; legal range 2..16.

Ports:
- clk  in  1  single system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous abort; same effect as rst on state, counters and outputs.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DW  input word; the first word accepted in a frame is the key.
- out_valid  out  1  flag is valid and held stable.
- out_ready  in  1  consumer accepts flag.
- flag  out  N  bit i = 1 when word i != word 0; bit 0 is always 0.
- busy  out  1  high in SCAN and DONE.

Behaviour:
- Reset (rst=1 or clr=1 at a clock edge):
  - state=LOAD, load index=0, scan index=1.
  - flag=0, out_valid=0, busy=0.
  - in_ready=1 from the first cycle after reset release.
  - Stored words are not cleared.
- rst and clr have priority over every other event, in every state, including mid-load and mid-scan.
- States:
  - LOAD:
    - in_ready=1.
    - Word accepted on in_valid&&in_ready; it is written to bank[load index] and the index increments.
    - When word N-1 is accepted, go to SCAN on the next edge and clear the flag register.
  - SCAN:
    - in_ready=0, busy=1.
    - Each cycle: flag[k] <= (bank[k] != bank[0]), k = scan index 1..N-1, then k increments.
    - After k=N-1, go to DONE.
    - SCAN lasts exactly N-1 cycles.
  - DONE:
    - out_valid=1; flag is held constant.
    - On out_valid&&out_ready: go to LOAD, reset both indices, out_valid=0 next cycle.
    - flag keeps its last value until the next SCAN begins.
- Latency: out_valid rises exactly N cycles after the edge that accepts word N-1 (7 cycles SCAN + 1 for N=8).
- Handshake rules:
  - in_valid is ignored outside LOAD.
  - out_ready is ignored outside DONE.
  - out_ready may be high before out_valid; the transfer completes in the first DONE cycle (one-cycle DONE).
  - Back-pressure: DONE may last indefinitely; no input is accepted meanwhile.
- Comparison is full-width unsigned equality; no masking.
- Index counters are ceil(log2(N)) bits wide. The load index does not wrap within a frame, because the terminal count forces the state change.
- flag[0] is tied to 0. Unused upper bits do not exist; flag is exactly N bits.

Optional Feature:
- Macro: MATCH_SCAN_COUNT_EN.
- Defined:
  - Adds output match_cnt, width ceil(log2(N)), registered, reset to 0.
  - Counts words 1..N-1 equal to the key.
  - Cleared at SCAN entry, incremented in the SCAN cycle that finds equality, valid with out_valid.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Package match_scan_pkg:
  - state enum {LOAD, SCAN, DONE};
  - default DW/N constants;
  - index width function clog2(N).
- One sub-module, match_word_bank:
  - N x DW register array;
  - one synchronous write port (we, waddr, wdata);
  - two asynchronous read ports (key = bank[0], bank[raddr]).
- The controller FSM, comparator and flag register stay in match_scan_ctrl.

Test Plan:
- Reset then words 0x5A,0x5A,0x00,0x5A,0xFF,0x5A,0x5A,0x12 with out_ready=1 -> flag=8'b1001_0100, out_valid exactly 8 cycles after the last accept, match_cnt=4 if enabled.
- All eight words 0x33 -> flag=8'h00; all words differing from key 0x00 -> flag=8'hFE; flag[0]=0 in both cases.
- in_valid toggled randomly during LOAD and held high through SCAN/DONE -> exactly 8 words captured, in_ready=0 during SCAN/DONE, no extra word captured.
- out_ready held low for 20 cycles in DONE -> out_valid and flag stable for 20 cycles; out_ready pulse -> in_ready=1 next cycle, second frame computed correctly.
- clr asserted after 4 words are loaded, then 8 new words -> the result reflects only the new frame; clr in SCAN cycle 3 -> flag=0, out_valid=0, state LOAD next cycle.
- rst asserted in DONE with out_ready=1 in the same cycle -> reset wins: out_valid=0 and flag=0 next cycle, no handshake completes.
